// File: rtl/warp_scheduler_pkg.sv
// rtl/warp_scheduler_pkg.sv - shared warp pipeline state encoding and core data width
package warp_scheduler_pkg;

  localparam int DATA_WIDTH = 32;

  // Pipeline state of the active warp, also decoded by the register file, decoder and ALU
  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6
  } warp_state_t;

endpackage

// File: rtl/warp_scheduler_rr_next_pending.sv
// rtl/warp_scheduler_rr_next_pending.sv - combinational round-robin search for the next pending index
module rr_next_pending #(
  parameter int NUM_WARPS = 4
) (
  input  logic [NUM_WARPS-1:0]         pending,
  input  logic [$clog2(NUM_WARPS)-1:0] cur_idx,
  output logic                         found,
  output logic [$clog2(NUM_WARPS)-1:0] next_idx
);

  // Scan from farthest to nearest so the nearest pending index above cur_idx wins;
  // offset NUM_WARPS lands back on cur_idx, so it is picked only when it is alone.
  always_comb begin
    found    = 1'b0;
    next_idx = cur_idx;
    for (int k = NUM_WARPS; k >= 1; k--) begin
      int idx;
      idx = (int'(cur_idx) + k) % NUM_WARPS;
      if (pending[idx]) begin
        found    = 1'b1;
        next_idx = ($clog2(NUM_WARPS))'(idx);
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-warp pipeline sequencer with round-robin switching; optional WARP_SCHED_WATCHDOG_EN stall watchdog
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS       = 4,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_WARPS-1:0]         launch_mask,
  input  logic                         fetch_ready,
  input  logic                         decoded_halt,
  input  logic                         lsu_waiting,
  output logic [NUM_WARPS-1:0]         warp_enable,
  output logic [$clog2(NUM_WARPS)-1:0] active_warp,
  output warp_state_t                  warp_state,
  output logic                         busy,
  output logic                         done,
  output logic                         watchdog_error
);

  localparam int IDX_W = $clog2(NUM_WARPS);

  warp_state_t          state_q;
  logic [NUM_WARPS-1:0] pending_q;
  logic [IDX_W-1:0]     active_q;
  logic [NUM_WARPS-1:0] warp_enable_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 wd_err_q;

  logic                 wd_fire;
  logic                 clear_active;
  logic                 switch_now;
  logic [NUM_WARPS-1:0] sel_pending;
  logic                 nxt_found;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 launch_any;
  logic [IDX_W-1:0]     first_idx;

  // A halt or a watchdog abort retires the active warp before the next one is chosen
  assign clear_active = (state_q == WARP_DECODE && decoded_halt) || wd_fire;
  assign switch_now   = clear_active || (state_q == WARP_UPDATE);
  assign sel_pending  = clear_active ? (pending_q & ~(NUM_WARPS'(1) << active_q)) : pending_q;

  rr_next_pending #(.NUM_WARPS(NUM_WARPS)) u_rr_next (
    .pending  (sel_pending),
    .cur_idx  (active_q),
    .found    (nxt_found),
    .next_idx (nxt_idx)
  );

  // Searching upward from the top index yields the lowest set bit of the launch mask
  rr_next_pending #(.NUM_WARPS(NUM_WARPS)) u_rr_first (
    .pending  (launch_mask),
    .cur_idx  (IDX_W'(NUM_WARPS - 1)),
    .found    (launch_any),
    .next_idx (first_idx)
  );

`ifdef WARP_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            stalled;

  assign stalled = (state_q == WARP_FETCH && !fetch_ready) || (state_q == WARP_WAIT && lsu_waiting);
  assign wd_fire = stalled && (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));

  // Count consecutive stalled cycles in FETCH/WAIT; any progress or abort restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (stalled && !wd_fire) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end else begin
      wd_cnt_q <= '0;
    end
  end
`else
  logic unused_cfg;

  assign wd_fire    = 1'b0;
  assign unused_cfg = (WATCHDOG_CYCLES != 0);
`endif

  // Pipeline FSM with registered outputs; warp switches land directly in FETCH with no bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WARP_IDLE;
      pending_q     <= '0;
      active_q      <= '0;
      warp_enable_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wd_err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WARP_IDLE: begin
          if (start) begin
            if (!launch_any) begin
              done_q <= 1'b1;
            end else begin
              pending_q     <= launch_mask;
              active_q      <= first_idx;
              warp_enable_q <= NUM_WARPS'(1) << first_idx;
              busy_q        <= 1'b1;
              state_q       <= WARP_FETCH;
            end
          end
        end
        WARP_FETCH:   if (fetch_ready) state_q <= WARP_DECODE;
        WARP_DECODE:  if (!decoded_halt) state_q <= WARP_REQUEST;
        WARP_REQUEST: state_q <= WARP_WAIT;
        WARP_WAIT:    if (!lsu_waiting) state_q <= WARP_EXECUTE;
        WARP_EXECUTE: state_q <= WARP_UPDATE;
        default:      ;
      endcase

      if (wd_fire) begin
        wd_err_q <= 1'b1;
      end

      if (switch_now) begin
        pending_q <= sel_pending;
        if (nxt_found) begin
          active_q      <= nxt_idx;
          warp_enable_q <= NUM_WARPS'(1) << nxt_idx;
          state_q       <= WARP_FETCH;
        end else begin
          warp_enable_q <= '0;
          busy_q        <= 1'b0;
          done_q        <= 1'b1;
          state_q       <= WARP_IDLE;
        end
      end
    end
  end

  assign warp_state     = state_q;
  assign active_warp    = active_q;
  assign warp_enable    = warp_enable_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign watchdog_error = wd_err_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - table-driven check of warp_scheduler sequencing, switching, reset and watchdog
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [3:0]        launch_mask;
  logic              fetch_ready;
  logic              decoded_halt;
  logic              lsu_waiting;
  logic [3:0]        warp_enable;
  logic [1:0]        active_warp;
  warp_state_t       warp_state;
  logic              busy;
  logic              done;
  logic              watchdog_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  warp_scheduler #(.NUM_WARPS(4), .WATCHDOG_CYCLES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .launch_mask    (launch_mask),
    .fetch_ready    (fetch_ready),
    .decoded_halt   (decoded_halt),
    .lsu_waiting    (lsu_waiting),
    .warp_enable    (warp_enable),
    .active_warp    (active_warp),
    .warp_state     (warp_state),
    .busy           (busy),
    .done           (done),
    .watchdog_error (watchdog_error)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic [3:0]  mask;
    logic        fr;
    logic        halt;
    logic        lw;
    warp_state_t st;
    logic [1:0]  act;
    logic        chk_act;
    logic [3:0]  en;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t       vq[$];
  logic       ns_start = 1'b0;
  logic [3:0] ns_mask  = 4'b0000;

  task automatic add(input logic rst, input logic st_in, input logic [3:0] mask, input logic fr,
                     input logic halt, input logic lw, input warp_state_t st, input int act,
                     input logic chk_act, input logic [3:0] en, input logic b, input logic d);
    vec_t v;
    v.rst = rst; v.start = st_in; v.mask = mask; v.fr = fr; v.halt = halt; v.lw = lw;
    v.st = st; v.act = 2'(act); v.chk_act = chk_act; v.en = en; v.busy = b; v.done = d;
    vq.push_back(v);
  endtask

  function automatic logic [3:0] oh(input int w);
    logic [3:0] one;
    one = 4'b0001;
    return one << w;
  endfunction

  task automatic add_reset();
    add(1, 0, 4'b0000, 0, 0, 0, WARP_IDLE, 0, 1, 4'b0000, 0, 0);
  endtask

  task automatic add_start(input logic [3:0] mask, input int first);
    add(0, 1, mask, 1, 0, 0, WARP_FETCH, first, 1, oh(first), 1, 0);
  endtask

  task automatic add_idle();
    add(0, 0, 4'b0000, 0, 0, 0, WARP_IDLE, 0, 0, 4'b0000, 0, 0);
  endtask

  // One instruction of warp w starting in FETCH; nxt < 0 means the kernel completes
  task automatic add_instr(input int w, input logic halt, input int nxt);
    add(0, ns_start, ns_mask, 1, 0, 0, WARP_DECODE, w, 1, oh(w), 1, 0);
    if (!halt) begin
      add(0, ns_start, ns_mask, 1, 0, 0, WARP_REQUEST, w, 1, oh(w), 1, 0);
      add(0, ns_start, ns_mask, 1, 0, 0, WARP_WAIT,    w, 1, oh(w), 1, 0);
      add(0, ns_start, ns_mask, 1, 0, 0, WARP_EXECUTE, w, 1, oh(w), 1, 0);
      add(0, ns_start, ns_mask, 1, 0, 0, WARP_UPDATE,  w, 1, oh(w), 1, 0);
    end
    if (nxt >= 0)
      add(0, ns_start, ns_mask, 1, 0, 0, WARP_FETCH, nxt, 1, oh(nxt), 1, 0);
    else
      add(0, ns_start, ns_mask, 1, halt, 0, WARP_IDLE, 0, 0, 4'b0000, 0, 1);
    if (halt) vq[vq.size() - 1 - ((nxt >= 0) ? 0 : 0)].halt = 1'b1;
  endtask

  task automatic chk(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s step %0d got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic s, input logic [3:0] m, input logic fr,
                       input logic h, input logic lw);
    reset = rst; start = s; launch_mask = m; fetch_ready = fr; decoded_halt = h; lsu_waiting = lw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; launch_mask = '0; fetch_ready = 1'b0;
    decoded_halt = 1'b0; lsu_waiting = 1'b0;

    // 1011 with no halts: round-robin 0,1,3,0,1,3, six cycles per instruction
    add_reset();
    add_start(4'b1011, 0);
    add_instr(0, 0, 1); add_instr(1, 0, 3); add_instr(3, 0, 0);
    add_instr(0, 0, 1); add_instr(1, 0, 3); add_instr(3, 0, 0);

    // 1011 with warp 1 halting on its second instruction, then 0 and 3 halting
    add_reset();
    add_start(4'b1011, 0);
    add_instr(0, 0, 1); add_instr(1, 0, 3); add_instr(3, 0, 0); add_instr(0, 0, 1);
    add_instr(1, 1, 3); add_instr(3, 0, 0); add_instr(0, 0, 3); add_instr(3, 0, 0);
    add_instr(0, 1, 3); add_instr(3, 1, -1);
    add_idle();

    // Warp 2 alone with a 5-cycle LSU stall, then reselected as sole pending warp
    add_reset();
    add_start(4'b0100, 2);
    add(0, 0, 4'b0000, 1, 0, 0, WARP_DECODE,  2, 1, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, WARP_REQUEST, 2, 1, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 1, WARP_WAIT,    2, 1, 4'b0100, 1, 0);
    for (int i = 0; i < 4; i++)
      add(0, 0, 4'b0000, 1, 0, 1, WARP_WAIT,  2, 1, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, WARP_EXECUTE, 2, 1, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, WARP_UPDATE,  2, 1, 4'b0100, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, WARP_FETCH,   2, 1, 4'b0100, 1, 0);
    add_instr(2, 1, -1);
    add_idle();

    // Empty launch: done next cycle, busy stays low
    add(0, 1, 4'b0000, 1, 0, 0, WARP_IDLE, 0, 0, 4'b0000, 0, 1);
    add_idle();

    // start during busy with a different mask must not disturb pending
    add_start(4'b0011, 0);
    ns_start = 1'b1; ns_mask = 4'b1111;
    add_instr(0, 0, 1); add_instr(1, 1, 0); add_instr(0, 1, -1);
    ns_start = 1'b0; ns_mask = 4'b0000;
    add_idle();

    // Reset while stalled in WAIT abandons the kernel without a done pulse
    add_start(4'b0001, 0);
    add(0, 0, 4'b0000, 1, 0, 0, WARP_DECODE,  0, 1, 4'b0001, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 0, WARP_REQUEST, 0, 1, 4'b0001, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 1, WARP_WAIT,    0, 1, 4'b0001, 1, 0);
    add(0, 0, 4'b0000, 1, 0, 1, WARP_WAIT,    0, 1, 4'b0001, 1, 0);
    add(1, 0, 4'b0000, 1, 0, 1, WARP_IDLE,    0, 1, 4'b0000, 0, 0);
    add_idle();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].start, vq[i].mask, vq[i].fr, vq[i].halt, vq[i].lw);
      chk("state", i, int'(warp_state), int'(vq[i].st));
      chk("enable", i, int'(warp_enable), int'(vq[i].en));
      chk("busy", i, int'(busy), int'(vq[i].busy));
      chk("done", i, int'(done), int'(vq[i].done));
      chk("wderr", i, int'(watchdog_error), 0);
      if (vq[i].chk_act) chk("active", i, int'(active_warp), int'(vq[i].act));
    end

    // Stuck fetch on warp 0 with warps 0 and 1 launched
    drive(1, 0, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b0011, 0, 0, 0);
    chk("wd_start_state", 0, int'(warp_state), int'(WARP_FETCH));
`ifdef WARP_SCHED_WATCHDOG_EN
    for (int i = 1; i <= 7; i++) begin
      drive(0, 0, 4'b0000, 0, 0, 0);
      chk("wd_hold_active", i, int'(active_warp), 0);
      chk("wd_hold_err", i, int'(watchdog_error), 0);
    end
    drive(0, 0, 4'b0000, 0, 0, 0);
    chk("wd_fire_err", 8, int'(watchdog_error), 1);
    chk("wd_fire_state", 8, int'(warp_state), int'(WARP_FETCH));
    chk("wd_fire_active", 8, int'(active_warp), 1);
    chk("wd_fire_enable", 8, int'(warp_enable), 2);
    drive(0, 0, 4'b0000, 0, 0, 0);
    chk("wd_sticky", 9, int'(watchdog_error), 1);
`else
    for (int i = 1; i <= 20; i++) begin
      drive(0, 0, 4'b0000, 0, 0, 0);
      chk("nowd_state", i, int'(warp_state), int'(WARP_FETCH));
      chk("nowd_active", i, int'(active_warp), 0);
      chk("nowd_err", i, int'(watchdog_error), 0);
    end
`endif
    drive(1, 0, 4'b0000, 0, 0, 0);
    chk("final_reset_err", 0, int'(watchdog_error), 0);
    chk("final_reset_state", 0, int'(warp_state), int'(WARP_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Sequences the per-warp execution pipeline of one compute core. It holds a pending bit per launched warp and serves one warp at a time through FETCH → DECODE → REQUEST → WAIT → EXECUTE → UPDATE. It drives that warp's one-hot enable and the shared warp state, which the scalar register file, decoder, ALU and LSU consume. Between instructions it rotates round-robin among the still-pending warps, and it signals completion when every launched warp has executed a halt.

## Interface
- NUM_WARPS, 4, number of warps (≥2).
- WATCHDOG_CYCLES, 1024, stall limit in FETCH/WAIT; used only with the watchdog feature.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high.
- start  in  1  launch pulse; sampled only in IDLE.
- launch_mask  in  NUM_WARPS  warps to launch on start.
- fetch_ready  in  1  instruction for the active warp is available.
- decoded_halt  in  1  instruction being decoded is a halt.
- lsu_waiting  in  1  active warp's LSU request is still outstanding.
- warp_enable  out  NUM_WARPS  one-hot enable of the active warp; all-zero in IDLE.
- active_warp  out  $clog2(NUM_WARPS)  index of the active warp.
- warp_state  out  warp_state_t  current pipeline state.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the last pending warp halts.
- watchdog_error  out  1  sticky stall flag.

## Operation
- States: WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE.
- IDLE + start:
  - pending ← launch_mask.
  - active_warp ← lowest set bit of launch_mask, then go to FETCH.
  - If launch_mask == 0: pulse done next cycle and stay in IDLE.
- FETCH: hold until fetch_ready = 1, then go to DECODE.
- DECODE (1 cycle):
  - If decoded_halt: clear pending[active_warp] and select the next warp (below).
  - Otherwise go to REQUEST.
- REQUEST (1 cycle): the register file latches rs1/rs2. Go to WAIT.
- WAIT: hold while lsu_waiting = 1, then go to EXECUTE.
- EXECUTE (1 cycle), then UPDATE (1 cycle): the register file writes back. After UPDATE, select the next warp.
- Next-warp selection:
  - Take the first pending warp searching upward from active_warp+1, wrapping modulo NUM_WARPS. The current warp is selected only if it is the sole pending warp.
  - Found: go to FETCH with the new warp.
  - None (pending == 0): pulse done, clear busy, go to IDLE.
- warp_enable = (state != IDLE) ? (1 << active_warp) : 0.
- start while busy is ignored. launch_mask bits ≥ NUM_WARPS do not exist; the width is exact.
- Reset:
  - Outputs: state IDLE, pending 0, active_warp 0, warp_enable 0, busy 0, done 0, watchdog_error 0, watchdog counter 0.
  - Reset mid-kernel abandons all warps immediately; no done pulse.

## Timing
- All outputs are registered. warp_state and warp_enable change on the same edge.
- Start to first FETCH: 1 cycle.
- Minimum instruction: 6 cycles (fetch_ready and lsu_waiting favourable). A warp switch adds no bubble; the UPDATE → FETCH edge carries the new active_warp.
- Halt instruction: FETCH + DECODE = 2 cycles minimum, then the switch.
- done is asserted the cycle after the final DECODE-halt or UPDATE; busy falls on the same edge.

## Configuration
- WARP_SCHED_WATCHDOG_EN defined:
  - A counter increments each consecutive cycle spent in FETCH or WAIT and clears on leaving them.
  - When it reaches WATCHDOG_CYCLES, the scheduler sets watchdog_error (sticky until reset), clears pending[active_warp] as if halted, and selects the next warp.
- Undefined: no counter; watchdog_error is tied 0; FETCH/WAIT wait indefinitely.

## Structure
- Shared package (common): the warp_state_t enum with the states above, which the register file, decoder and ALU already use, plus the DATA_WIDTH define.
- One natural sub-module, rr_next_pending: combinational round-robin search taking pending and current index and returning found plus the next index. Reusable by the LSU arbiter.

## Test plan
- launch_mask=4'b1011, fetch_ready=1, lsu_waiting=0, no halts: warps visit in order 0,1,3,0,1,3, each instruction exactly 6 cycles; warp_enable one-hot matches.
- Same mask, halt warp 1 on its second instruction: the sequence continues 3,0,3,0. After halts for 0 and 3, done pulses once and busy falls.
- lsu_waiting held for 5 cycles on warp 2: WAIT lasts 5 cycles and EXECUTE follows on the 6th. No other warp is enabled meanwhile.
- start with launch_mask=0: done pulses the next cycle; busy never rises; state stays IDLE. A start pulse during busy leaves pending unchanged.
- Reset asserted during WAIT: next cycle warp_state=IDLE, warp_enable=0, busy=0, no done pulse.
- WARP_SCHED_WATCHDOG_EN with WATCHDOG_CYCLES=8 and fetch_ready stuck 0 on warp 0: after 8 FETCH cycles, watchdog_error=1 and the scheduler moves to warp 1. Without the macro, it stays in FETCH indefinitely.
